// File: rtl/mem_pkg.sv
// Shared FSM state type, line geometry and address helper for mem_burst_responder.
// The BURST state only exists when MEM_BURST_EN is defined.
package mem_pkg;

  localparam int unsigned BURST_LEN        = 8;
  localparam int unsigned LINE_OFFSET_BITS = 3;

`ifdef MEM_BURST_EN
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_e;
`endif

  // Byte address of the word k positions after word_addr, wrapping inside its line.
  function automatic logic [15:0] line_wrap_addr(input logic [15:1]                 word_addr,
                                                 input logic [LINE_OFFSET_BITS-1:0] k);
    logic [LINE_OFFSET_BITS-1:0] off;
    off = word_addr[LINE_OFFSET_BITS:1] + k;
    return {word_addr[15:LINE_OFFSET_BITS+1], off, 1'b0};
  endfunction

endpackage

// File: rtl/mem_array.sv
// 2**DEPTH_LOG2 x 16 storage: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module mem_array #(
  parameter int unsigned DEPTH_LOG2 = 15
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [15:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [15:0]           rdata_o
);

  logic [15:0] mem_q [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_burst_responder.sv
// Fixed-latency memory responder: writes commit on acceptance, reads answer after
// LATENCY cycles; critical-word-first 8-word bursts when MEM_BURST_EN is defined.
module mem_burst_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_burst,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_addr
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e      state_q;
  logic        ready_q;
  logic [3:0]  lat_cnt_q;
  logic [15:1] base_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic [15:0] rsp_addr_q;
  logic [15:0] next_addr;
  logic [15:0] rdata;
  logic        wr_en;
  logic        unused_ok;

`ifdef MEM_BURST_EN
  logic                        burst_q;
  logic [LINE_OFFSET_BITS-1:0] beat_q;
  assign unused_ok = req_addr[0];
`else
  assign unused_ok = req_addr[0] ^ req_burst;
`endif

  // Address of the word captured at the next edge: the latched base for the first
  // word, otherwise the successor of the word currently on the output.
  always_comb begin
    next_addr = {base_q, 1'b0};
`ifdef MEM_BURST_EN
    if (state_q == BURST) begin
      next_addr = line_wrap_addr(rsp_addr_q[15:1], LINE_OFFSET_BITS'(1));
    end
`endif
  end

  assign wr_en = rst_n && ready_q && req_valid && req_wr;

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (req_addr[DEPTH_LOG2:1]),
    .wdata_i (req_wdata),
    .raddr_i (next_addr[DEPTH_LOG2:1]),
    .rdata_o (rdata)
  );

  // WAIT covers LATENCY-1 counting cycles plus, for single reads, the response cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      lat_cnt_q   <= '0;
      base_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
`ifdef MEM_BURST_EN
      burst_q     <= 1'b0;
      beat_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && !req_wr) begin
            state_q   <= WAIT;
            ready_q   <= 1'b0;
            lat_cnt_q <= LAT_M1;
            base_q    <= req_addr[15:1];
`ifdef MEM_BURST_EN
            burst_q   <= req_burst;
`endif
          end
        end
        WAIT: begin
          if (lat_cnt_q > 4'd1) begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end else if (lat_cnt_q == 4'd1) begin
            lat_cnt_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rdata;
            rsp_addr_q  <= next_addr;
`ifdef MEM_BURST_EN
            if (burst_q) begin
              state_q <= BURST;
              beat_q  <= '0;
            end
`endif
          end else begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        end
`ifdef MEM_BURST_EN
        BURST: begin
          if (beat_q == LINE_OFFSET_BITS'(BURST_LEN - 1)) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
          end else begin
            beat_q      <= beat_q + 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rdata;
            rsp_addr_q  <= next_addr;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: LATENCY=4 instance plus a LATENCY=2 instance.
// Burst expectations follow MEM_BURST_EN.
module tb_mem_burst_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_wr, req_burst;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data, rsp_addr;

  logic        req_valid2, req_ready2, req_wr2, req_burst2;
  logic [15:0] req_addr2, req_wdata2;
  logic        rsp_valid2;
  logic [15:0] rsp_data2, rsp_addr2;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  int          q_cyc[$];
  logic [15:0] q_addr[$];
  logic [15:0] q_data[$];

  mem_burst_responder #(.LATENCY(4), .DEPTH_LOG2(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr)
  );

  mem_burst_responder #(.LATENCY(2), .DEPTH_LOG2(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_wr(req_wr2), .req_burst(req_burst2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_addr(rsp_addr2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Waits for ready, presents one request for exactly one accepting edge; acc = accept edge index.
  task automatic issue(input bit d2, input bit wr, input bit burst,
                       input logic [15:0] addr, input logic [15:0] wdata, output int acc);
    int w;
    acc = -1;
    for (w = 0; w < 50; w++) begin
      @(negedge clk);
      if (d2 ? req_ready2 : req_ready) break;
    end
    if (w == 50) begin
      vec++; errs++;
      $display("FAIL issue_timeout: req_ready never rose for addr %h", addr);
      return;
    end
    if (d2) begin
      req_valid2 = 1'b1; req_wr2 = wr; req_burst2 = burst; req_addr2 = addr; req_wdata2 = wdata;
    end else begin
      req_valid = 1'b1; req_wr = wr; req_burst = burst; req_addr = addr; req_wdata = wdata;
    end
    acc = cyc + 1;
    @(posedge clk);
    #1;
    if (d2) req_valid2 = 1'b0;
    else    req_valid  = 1'b0;
  endtask

  task automatic collect(input bit d2, input int ncyc);
    q_cyc.delete(); q_addr.delete(); q_data.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (d2 ? rsp_valid2 : rsp_valid) begin
        q_cyc.push_back(cyc);
        q_addr.push_back(d2 ? rsp_addr2 : rsp_addr);
        q_data.push_back(d2 ? rsp_data2 : rsp_data);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 0; req_wr = 0; req_burst = 0; req_addr = '0; req_wdata = '0;
    req_valid2 = 0; req_wr2 = 0; req_burst2 = 0; req_addr2 = '0; req_wdata2 = '0;
    repeat (3) @(negedge clk);
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    vec++; if (rsp_data !== 16'h0000) begin errs++; $display("FAIL reset_data: got %h expected 0000", rsp_data); end
    vec++; if (rsp_addr !== 16'h0000) begin errs++; $display("FAIL reset_addr: got %h expected 0000", rsp_addr); end
    vec++; if (req_ready2 !== 1'b1) begin errs++; $display("FAIL reset_ready2: got %b expected 1", req_ready2); end
    vec++; if (rsp_valid2 !== 1'b0) begin errs++; $display("FAIL reset_valid2: got %b expected 0", rsp_valid2); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    int a;
    issue(0, 1, 0, 16'h0010, 16'hBEEF, a);
    collect(0, 3);
    vec++; if (q_cyc.size() != 0) begin errs++; $display("FAIL write_no_rsp: got %0d responses expected 0", q_cyc.size()); end
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL write_stays_idle: ready %b expected 1", req_ready); end
    issue(0, 0, 0, 16'h0010, 16'h0000, a);
    collect(0, 10);
    vec++; if (q_cyc.size() != 1) begin errs++; $display("FAIL read_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_cyc[0] - a + 1 != 4) begin errs++; $display("FAIL read_latency: got %0d expected 4", q_cyc[0] - a + 1); end
      vec++; if (q_data[0] !== 16'hBEEF) begin errs++; $display("FAIL read_data: got %h expected beef", q_data[0]); end
      vec++; if (q_addr[0] !== 16'h0010) begin errs++; $display("FAIL read_addr: got %h expected 0010", q_addr[0]); end
    end
    issue(0, 0, 0, 16'h0011, 16'h0000, a);
    collect(0, 10);
    vec++; if (q_cyc.size() != 1) begin errs++; $display("FAIL odd_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_data[0] !== 16'hBEEF) begin errs++; $display("FAIL odd_data: got %h expected beef", q_data[0]); end
      vec++; if (q_addr[0] !== 16'h0010) begin errs++; $display("FAIL odd_addr: got %h expected 0010", q_addr[0]); end
    end
  endtask

  task automatic test_read_after_write;
    int aw, ar;
    issue(0, 1, 0, 16'h0020, 16'h1111, aw);
    issue(0, 1, 0, 16'h0020, 16'h1234, aw);
    issue(0, 0, 0, 16'h0020, 16'h0000, ar);
    vec++; if (ar != aw + 1) begin errs++; $display("FAIL raw_accept: read at %0d expected %0d", ar, aw + 1); end
    collect(0, 10);
    vec++; if (q_cyc.size() != 1) begin errs++; $display("FAIL raw_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_data[0] !== 16'h1234) begin errs++; $display("FAIL raw_data: got %h expected 1234", q_data[0]); end
    end
  endtask

  task automatic preload;
    int a;
    for (int i = 0; i < 8; i++) begin
      issue(0, 1, 0, 16'(16'h0040 + 2 * i), 16'(16'h1000 + i), a);
    end
  endtask

  task automatic test_burst;
    int a;
    logic [15:0] ea [8];
    logic [15:0] ed [8];
    ea = '{16'h0046, 16'h0048, 16'h004A, 16'h004C, 16'h004E, 16'h0040, 16'h0042, 16'h0044};
    ed = '{16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007, 16'h1000, 16'h1001, 16'h1002};
    issue(0, 0, 1, 16'h0046, 16'h0000, a);
    collect(0, 20);
`ifdef MEM_BURST_EN
    vec++; if (q_cyc.size() != 8) begin errs++; $display("FAIL burst_count: got %0d expected 8", q_cyc.size()); end
    if (q_cyc.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        vec++; if (q_cyc[k] - a + 1 != 4 + k) begin errs++; $display("FAIL burst_timing[%0d]: got %0d expected %0d", k, q_cyc[k] - a + 1, 4 + k); end
        vec++; if (q_addr[k] !== ea[k]) begin errs++; $display("FAIL burst_addr[%0d]: got %h expected %h", k, q_addr[k], ea[k]); end
        vec++; if (q_data[k] !== ed[k]) begin errs++; $display("FAIL burst_data[%0d]: got %h expected %h", k, q_data[k], ed[k]); end
      end
    end
`else
    vec++; if (q_cyc.size() != 1) begin errs++; $display("FAIL noburst_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_cyc[0] - a + 1 != 4) begin errs++; $display("FAIL noburst_latency: got %0d expected 4", q_cyc[0] - a + 1); end
      vec++; if (q_addr[0] !== ea[0]) begin errs++; $display("FAIL noburst_addr: got %h expected %h", q_addr[0], ea[0]); end
      vec++; if (q_data[0] !== ed[0]) begin errs++; $display("FAIL noburst_data: got %h expected %h", q_data[0], ed[0]); end
    end
`endif
  endtask

  task automatic test_back_to_back;
    int a_burst, a_held, busy, nrsp, exp_busy, exp_rsp, w;
    logic [15:0] last_d, last_a;
`ifdef MEM_BURST_EN
    exp_busy = 4 + 7; exp_rsp = 9;
`else
    exp_busy = 4;     exp_rsp = 2;
`endif
    for (w = 0; w < 50; w++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    vec++; if (w == 50) begin errs++; $display("FAIL b2b_start: ready %b expected 1", req_ready); end
    req_valid = 1'b1; req_wr = 1'b0; req_burst = 1'b1; req_addr = 16'h0046;
    a_burst = cyc + 1;
    @(posedge clk);
    #1;
    req_burst = 1'b0; req_addr = 16'h0040;
    busy = 0; nrsp = 0; a_held = -1; last_d = '0; last_a = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin nrsp++; last_d = rsp_data; last_a = rsp_addr; end
      if (a_held < 0) begin
        if (!req_ready) busy++;
        else begin
          a_held = cyc + 1;
          @(posedge clk);
          #1;
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    vec++; if (busy != exp_busy) begin errs++; $display("FAIL held_busy: got %0d expected %0d", busy, exp_busy); end
    vec++; if (a_held != a_burst + exp_busy + 1) begin errs++; $display("FAIL held_accept: got %0d expected %0d", a_held, a_burst + exp_busy + 1); end
    vec++; if (nrsp != exp_rsp) begin errs++; $display("FAIL held_rsp_count: got %0d expected %0d", nrsp, exp_rsp); end
    vec++; if (last_d !== 16'h1000) begin errs++; $display("FAIL held_data: got %h expected 1000", last_d); end
    vec++; if (last_a !== 16'h0040) begin errs++; $display("FAIL held_addr: got %h expected 0040", last_a); end
  endtask

  task automatic test_reset_mid_burst;
    int a, seen;
    seen = 0;
`ifdef MEM_BURST_EN
    issue(0, 0, 1, 16'h0046, 16'h0000, a);
    for (int i = 0; i < 30 && seen < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    vec++; if (seen != 3) begin errs++; $display("FAIL rstmid_words: got %0d expected 3", seen); end
`else
    issue(0, 0, 0, 16'h0046, 16'h0000, a);
    repeat (2) @(negedge clk);
`endif
    rst_n = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_burst = 1'b0; req_addr = 16'h0040; req_wdata = 16'hDEAD;
    @(negedge clk);
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %b expected 0", rsp_valid); end
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
    collect(0, 12);
    vec++; if (q_cyc.size() != 0) begin errs++; $display("FAIL rstmid_abort: got %0d responses expected 0", q_cyc.size()); end
    issue(0, 0, 0, 16'h0040, 16'h0000, a);
    collect(0, 10);
    vec++; if (q_cyc.size() != 1) begin errs++; $display("FAIL rstmid_read_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_data[0] !== 16'h1000) begin errs++; $display("FAIL rstmid_data: got %h expected 1000", q_data[0]); end
      vec++; if (q_addr[0] !== 16'h0040) begin errs++; $display("FAIL rstmid_addr: got %h expected 0040", q_addr[0]); end
    end
  endtask

  task automatic test_latency2;
    int a, n_acc;
    int acc [3];
    logic [15:0] addrs [3];
    logic [15:0] ed [3];
    addrs = '{16'h0050, 16'h0052, 16'h0050};
    ed    = '{16'hA5A5, 16'h5A5A, 16'hA5A5};
    issue(1, 1, 0, 16'h0050, 16'hA5A5, a);
    issue(1, 1, 0, 16'h0052, 16'h5A5A, a);
    issue(1, 0, 0, 16'h0052, 16'h0000, a);
    collect(1, 6);
    vec++; if (q_cyc.size() != 1) begin errs++; $display("FAIL lat2_count: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      vec++; if (q_cyc[0] - a + 1 != 2) begin errs++; $display("FAIL lat2_latency: got %0d expected 2", q_cyc[0] - a + 1); end
      vec++; if (q_data[0] !== 16'h5A5A) begin errs++; $display("FAIL lat2_data: got %h expected 5a5a", q_data[0]); end
    end
    n_acc = 0;
    acc = '{-1, -1, -1};
    q_cyc.delete(); q_addr.delete(); q_data.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid2) begin q_cyc.push_back(cyc); q_data.push_back(rsp_data2); end
      if (n_acc < 3 && req_ready2) begin
        acc[n_acc] = cyc + 1;
        req_valid2 = 1'b1; req_wr2 = 1'b0; req_burst2 = 1'b0; req_addr2 = addrs[n_acc];
        n_acc++;
      end else begin
        req_valid2 = 1'b0;
      end
    end
    vec++; if (n_acc != 3) begin errs++; $display("FAIL b2b2_accepts: got %0d expected 3", n_acc); end
    vec++; if (acc[1] - acc[0] != 3) begin errs++; $display("FAIL b2b2_gap0: got %0d expected 3", acc[1] - acc[0]); end
    vec++; if (acc[2] - acc[1] != 3) begin errs++; $display("FAIL b2b2_gap1: got %0d expected 3", acc[2] - acc[1]); end
    vec++; if (q_cyc.size() != 3) begin errs++; $display("FAIL b2b2_count: got %0d expected 3", q_cyc.size()); end
    if (q_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        vec++; if (q_cyc[k] - acc[k] + 1 != 2) begin errs++; $display("FAIL b2b2_latency[%0d]: got %0d expected 2", k, q_cyc[k] - acc[k] + 1); end
        vec++; if (q_data[k] !== ed[k]) begin errs++; $display("FAIL b2b2_data[%0d]: got %h expected %h", k, q_data[k], ed[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_after_write();
    preload();
    test_burst();
    test_back_to_back();
    test_reset_mid_burst();
    test_latency2();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
